// File: rtl/ram_if.sv
// Bus bundle for the single-port data memory: enable, read/write select,
// word address, write data and registered read data.
interface ram_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  Enable;
    logic                  ReadWrite;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] DataIn;
    logic [DATA_WIDTH-1:0] DataOut;

    modport master (
        output Enable,
        output ReadWrite,
        output Address,
        output DataIn,
        input  DataOut
    );

    modport slave (
        input  Enable,
        input  ReadWrite,
        input  Address,
        input  DataIn,
        output DataOut
    );
endinterface

// File: rtl/ram.sv
// Single-port synchronous word-addressed data memory with a registered read
// port; Reset clears only the read register, never the array.
module ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
    input logic   Clock,
    input logic   Reset,
    ram_if.slave  bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Array starts all-zero; the initialiser is the power-up image, not a reset.
    logic [DATA_WIDTH-1:0] Mem [0:DEPTH-1] = '{default: '0};

    logic [IDX_W-1:0] idx;
    logic             wr_en;
    logic             rd_en;

    // Address wraps modulo DEPTH when the array is smaller than the address space.
    assign idx   = IDX_W'(32'(bus.Address) % DEPTH);
    assign wr_en = !Reset && bus.Enable && !bus.ReadWrite;
    assign rd_en = !Reset && bus.Enable &&  bus.ReadWrite;

    always_ff @(posedge Clock) begin
        if (wr_en) begin
            Mem[idx] <= bus.DataIn;
        end
    end

    // Read register: cleared by reset, loaded only on a read, held otherwise.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            bus.DataOut <= '0;
        end else if (rd_en) begin
            bus.DataOut <= Mem[idx];
        end
    end
endmodule

// File: tb/tb_ram.sv
// Directed, table-driven bench for the data memory: each record is one clock
// of stimulus plus the DataOut value required after that edge.
module tb_ram;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;
    localparam int unsigned NW = 2 ** AW;

    typedef struct {
        logic          rst;
        logic          en;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
        string         name;
    } vec_t;

    logic Clock = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;

    logic [DW-1:0] init_vals [0:7];
    vec_t          tbl [$];

    function automatic vec_t mk(input logic rst, input logic en, input logic rw,
                                input logic [AW-1:0] addr, input logic [DW-1:0] din,
                                input logic [DW-1:0] dout, input string name);
        vec_t v;
        v.rst = rst; v.en = en; v.rw = rw; v.addr = addr;
        v.din = din; v.dout = dout; v.name = name;
        return v;
    endfunction

    // Drive one cycle of stimulus at the falling edge, check just after the rising edge.
    task automatic apply(input vec_t v);
        @(negedge Clock);
        Reset         = v.rst;
        bus.Enable    = v.en;
        bus.ReadWrite = v.rw;
        bus.Address   = v.addr;
        bus.DataIn    = v.din;
        @(posedge Clock);
        #1;
        checks++;
        if (bus.DataOut !== v.dout) begin
            errors++;
            $display("FAIL %s: DataOut got %08h expected %08h", v.name, bus.DataOut, v.dout);
        end
    endtask

    task automatic check_word(input int unsigned a, input logic [DW-1:0] exp, input string name);
        checks++;
        if (dut.Mem[a] !== exp) begin
            errors++;
            $display("FAIL %s: Mem[%04h] got %08h expected %08h", name, a, dut.Mem[a], exp);
        end
    endtask

    // Whole-array image after the sequential writes: table at 0-7, zero elsewhere.
    task automatic check_image();
        int bad = 0;
        int first_bad = -1;
        logic [DW-1:0] exp;
        for (int j = 0; j < int'(NW); j++) begin
            exp = (j < 8) ? init_vals[j] : '0;
            if (dut.Mem[j] !== exp) begin
                bad++;
                if (first_bad < 0) first_bad = j;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mem_image: %0d words wrong, first at %04h got %08h", bad, first_bad,
                     dut.Mem[first_bad]);
        end
    endtask

    initial begin
        init_vals[0] = 32'hAAAAAAAA; init_vals[1] = 32'h00AABBCC;
        init_vals[2] = 32'h00BB2351; init_vals[3] = 32'h00CCFFFF;
        init_vals[4] = 32'h00DDABCD; init_vals[5] = 32'h00000000;
        init_vals[6] = 32'hFFFFEFFF; init_vals[7] = 32'hEEEEEEEE;

        Reset = 1'b1; bus.Enable = 1'b0; bus.ReadWrite = 1'b0;
        bus.Address = '0; bus.DataIn = '0;

        // Phase 1: reset, then sequential writes with DataOut held at zero.
        tbl.push_back(mk(1, 0, 0, 16'h0000, 32'h0, 32'h0, "reset"));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 1, 0, 16'(i), init_vals[i], 32'h0, $sformatf("wr%0d", i)));
        foreach (tbl[i]) apply(tbl[i]);
        check_image();
        tbl.delete();

        // Phase 2: readback, enable gating, reset priority, boundaries.
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 1, 1, 16'(i), 32'h0, init_vals[i], $sformatf("rd%0d", i)));
        tbl.push_back(mk(0, 0, 0, 16'h0003, 32'h12345678, 32'hEEEEEEEE, "idle_wr"));
        tbl.push_back(mk(0, 0, 1, 16'h0001, 32'h0,        32'hEEEEEEEE, "idle_rd"));
        tbl.push_back(mk(0, 1, 1, 16'h0003, 32'h0,        32'h00CCFFFF, "rd3_after_idle"));
        tbl.push_back(mk(0, 1, 1, 16'h0004, 32'h0,        32'h00DDABCD, "rd4_pre_reset"));
        tbl.push_back(mk(1, 1, 0, 16'h0004, 32'h0BADF00D, 32'h0,        "reset_with_wr"));
        tbl.push_back(mk(0, 1, 1, 16'h0004, 32'h0,        32'h00DDABCD, "rd4_post_reset"));
        tbl.push_back(mk(0, 1, 1, 16'h0007, 32'h0,        32'hEEEEEEEE, "rd7_post_reset"));
        tbl.push_back(mk(0, 1, 0, 16'hFFFF, 32'hFFFFFFFF, 32'hEEEEEEEE, "wr_top_hold"));
        tbl.push_back(mk(0, 1, 1, 16'hFFFF, 32'h0,        32'hFFFFFFFF, "rd_top"));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 32'h00000001, 32'hFFFFFFFF, "wr0_hold"));
        tbl.push_back(mk(0, 1, 1, 16'h0000, 32'h0,        32'h00000001, "rd0_new"));
        tbl.push_back(mk(1, 1, 1, 16'h0007, 32'h0,        32'h0,        "reset_with_rd"));
        tbl.push_back(mk(0, 0, 1, 16'h0007, 32'h0,        32'h0,        "idle_after_reset"));
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();

        check_word(32'h0004, 32'h00DDABCD, "mem4_survives_reset");
        check_word(32'h0003, 32'h00CCFFFF, "mem3_idle_no_write");
        check_word(32'hFFFF, 32'hFFFFFFFF, "mem_top");
        check_word(32'hFFFE, 32'h00000000, "mem_below_top");

        // Back-to-back write/read/overwrite/read on one address with no bubbles.
        apply(mk(0, 1, 0, 16'h1234, 32'hDEADBEEF, 32'h0,        "b2b_wr_a"));
        apply(mk(0, 1, 1, 16'h1234, 32'h0,        32'hDEADBEEF, "b2b_rd_a"));
        apply(mk(0, 1, 0, 16'h1234, 32'h5A5A5A5A, 32'hDEADBEEF, "b2b_wr_b"));
        apply(mk(0, 1, 1, 16'h1234, 32'h0,        32'h5A5A5A5A, "b2b_rd_b"));
        apply(mk(0, 1, 1, 16'h0006, 32'h0,        32'hFFFFEFFF, "b2b_rd6"));
        apply(mk(0, 1, 1, 16'h0005, 32'h0,        32'h00000000, "b2b_rd5_zero"));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram.md
# ram

Single-port synchronous data memory for the 32-bit processor: 65,536 words of 32 bits, addressed by word. The block serves as the processor's main data/program store and is written and read over one shared address bus, with a single read/write select and an enable. The storage array is named `Mem` so benches can dump it hierarchically (e.g. with `$writememh`).

## Interface

Parameters:
- `DATA_WIDTH`, default 32: word width in bits.
- `ADDR_WIDTH`, default 16: word-address width in bits.
- `DEPTH`, default 2**ADDR_WIDTH (65536): number of words in `Mem`.

Ports:
- `Clock`: input, 1 bit. Single clock; all state updates on its rising edge.
- `Reset`: input, 1 bit. Synchronous, active-high.
- `Enable`: input, 1 bit. 1 means perform the access selected by `ReadWrite`; 0 means idle.
- `ReadWrite`: input, 1 bit. 0 means write, 1 means read.
- `Address`: input, ADDR_WIDTH bits. Word address.
- `DataIn`: input, DATA_WIDTH bits. Write data.
- `DataOut`: output, DATA_WIDTH bits. Registered read data.

## Operation

- Storage: `reg [DATA_WIDTH-1:0] Mem [0:DEPTH-1]`.
  - Every word is initialised to 0 at time zero (simulation initial block / FPGA init).
  - The array is not cleared by `Reset`.
- Write (`Enable`=1, `ReadWrite`=0):
  - At the rising edge, `Mem[Address]` takes the value of `DataIn`.
  - `DataOut` holds its previous value; there is no write-through.
- Read (`Enable`=1, `ReadWrite`=1):
  - At the rising edge, `DataOut` takes the value of `Mem[Address]`.
  - `Mem` is unchanged.
- Idle (`Enable`=0):
  - No change to `Mem` or `DataOut`, whatever the values of `ReadWrite`, `Address` and `DataIn`.
- Reset (`Reset`=1 at a rising edge):
  - `DataOut` becomes 0.
  - Any access requested in that same cycle is ignored: no write, no read.
  - `Reset` has priority over `Enable`.
- Addressing:
  - The full 16-bit address space is implemented, so every address is valid.
  - With non-default parameters where DEPTH < 2**ADDR_WIDTH, only the low log2(DEPTH) address bits are used, and the address wraps modulo DEPTH.
- Data width:
  - Full-word accesses only; there are no byte enables.
  - All DATA_WIDTH bits are stored and returned unmodified, including all-zero and all-one patterns.
- X/Z on control inputs is not guarded against; the driver must keep `Enable` and `ReadWrite` at known values.

## Timing

- Write latency: 1 cycle. Data presented before edge N is in `Mem` after edge N and is readable with a read issued at edge N+1.
- Read latency: 1 cycle. `DataOut` is valid after the rising edge on which the read is sampled, and is held until the next read or reset.
- Back-to-back accesses: one access per cycle, in any mix of reads and writes, with no bubbles.
- Read of an address written on the immediately preceding edge returns the new data.
- Output value after reset: `DataOut` = 32'h00000000.
- A reset in the middle of a sequence leaves all previously written words intact. Only `DataOut` is cleared.
- Inputs must meet setup and hold at `Clock`. No combinational path exists from any input to `DataOut`.

## Test plan

- Sequential writes: with `Enable`=1 and `ReadWrite`=0, write one word per cycle to addresses 0–7:
  - address 0 → AAAAAAAA
  - address 1 → 00AABBCC
  - address 2 → 00BB2351
  - address 3 → 00CCFFFF
  - address 4 → 00DDABCD
  - address 5 → 00000000
  - address 6 → FFFFEFFF
  - address 7 → EEEEEEEE
  
  Required: a `$writememh` dump of `Mem` shows exactly those values at 0–7 and 0 at all other locations; `DataOut` stays 0 throughout.
- Readback: after the writes above, read addresses 0–7 on consecutive cycles. Required: `DataOut` shows each stored value one cycle after its address is presented, e.g. address 2 returns 00BB2351 and address 6 returns FFFFEFFF.
- Enable gating:
  - With `Enable`=0 and `ReadWrite`=0, present address 3 with data 12345678. Required: `Mem[3]` is still 00CCFFFF.
  - With `Enable`=0 and `ReadWrite`=1, present address 1. Required: `DataOut` unchanged.
- Reset behaviour: read address 4 (`DataOut`=00DDABCD), then assert `Reset` together with a write of 0BADF00D to address 4. Required:
  - `DataOut`=0 after the edge;
  - `Mem[4]` is still 00DDABCD;
  - a subsequent read of address 7 returns EEEEEEEE.
- Boundaries and write-then-read:
  - Write FFFFFFFF to address FFFF, then read it on the next cycle. Required: `DataOut`=FFFFFFFF.
  - Write 00000001 to address 0 and read address 0 on the following cycle. Required: `DataOut`=00000001.
